// File: rtl/signal_measure_core.sv
// Single-shot frequency / duty-cycle meter: times one full period of sig_in in
// clk cycles, then derives Hz and percent with two sequential restoring dividers.
`timescale 1ns/1ps
module signal_measure_core #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sig_in,
  output logic        busy,
  output logic        finish,
  output logic [19:0] freq,
  output logic [7:0]  duty,
  output logic [19:0] high_time,
  output logic [19:0] low_time
);

  localparam logic [19:0] CNT_MAX   = 20'hFFFFF;
  localparam logic [31:0] DIV_FREQ  = 32'(CLK_FREQ);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [19:0] hcnt_q, hcnt_d;
  logic [19:0] lcnt_q, lcnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic [20:0] period_q, period_d;
  logic [31:0] fdvd_q, fdvd_d;
  logic [31:0] ddvd_q, ddvd_d;
  logic [20:0] frem_q, frem_d;
  logic [20:0] drem_q, drem_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        busy_q, busy_d;
  logic        finish_q, finish_d;
  logic [19:0] freq_q, freq_d;
  logic [7:0]  duty_q, duty_d;
  logic [19:0] high_q, high_d;
  logic [19:0] low_q, low_d;

  logic        rise;
  logic        fall;
  logic        wdog_hit;
  logic [20:0] period_sum;
  logic [20:0] half_period;
  logic [21:0] fshift, dshift;
  logic [21:0] fdiff, ddiff;
  logic        fge, dge;

  always_comb begin
    rise        = sync2_q & ~prev_q;
    fall        = ~sync2_q & prev_q;
    wdog_hit    = (wdog_q >= WDOG_LAST);
    period_sum  = {1'b0, hcnt_q} + {1'b0, lcnt_q};
    half_period = period_sum >> 1;

    // One restoring-division step per divider: shift in the next dividend bit,
    // subtract the divisor when it fits; the quotient bit replaces the dividend LSB.
    fshift = {frem_q, fdvd_q[31]};
    dshift = {drem_q, ddvd_q[31]};
    fdiff  = fshift - {1'b0, period_q};
    ddiff  = dshift - {1'b0, period_q};
    fge    = (fshift >= {1'b0, period_q});
    dge    = (dshift >= {1'b0, period_q});
  end

  always_comb begin
    state_d   = state_q;
    sync1_d   = sig_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    period_d  = period_q;
    fdvd_d    = fdvd_q;
    ddvd_d    = ddvd_q;
    frem_d    = frem_q;
    drem_d    = drem_q;
    bit_cnt_d = bit_cnt_q;
    finish_d  = 1'b0;
    freq_d    = freq_q;
    duty_d    = duty_q;
    high_d    = high_q;
    low_d     = low_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = WAIT_RISE;
          hcnt_d    = '0;
          lcnt_d    = '0;
          wdog_d    = '0;
          timeout_d = 1'b0;
        end
      end

      WAIT_RISE: begin
        wdog_d = wdog_q + 32'd1;
        if (wdog_hit) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (rise) begin
          hcnt_d  = 20'd1;
          wdog_d  = '0;
          state_d = MEAS_HIGH;
        end
      end

      MEAS_HIGH: begin
        wdog_d = wdog_q + 32'd1;
        if (wdog_hit) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (fall) begin
          lcnt_d  = 20'd1;
          wdog_d  = '0;
          state_d = MEAS_LOW;
        end else if (sync2_q && (hcnt_q != CNT_MAX)) begin
          hcnt_d = hcnt_q + 20'd1;
        end
      end

      MEAS_LOW: begin
        wdog_d = wdog_q + 32'd1;
        if (wdog_hit) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (rise) begin
          // Adding half the divisor to each dividend turns truncation into rounding.
          period_d  = period_sum;
          fdvd_d    = DIV_FREQ + 32'(half_period);
          ddvd_d    = (32'(hcnt_q) * 32'd100) + 32'(half_period);
          frem_d    = '0;
          drem_d    = '0;
          bit_cnt_d = '0;
          state_d   = CALC;
        end else if (!sync2_q && (lcnt_q != CNT_MAX)) begin
          lcnt_d = lcnt_q + 20'd1;
        end
      end

      CALC: begin
        fdvd_d    = {fdvd_q[30:0], fge};
        ddvd_d    = {ddvd_q[30:0], dge};
        frem_d    = fge ? fdiff[20:0] : fshift[20:0];
        drem_d    = dge ? ddiff[20:0] : dshift[20:0];
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end

      DONE: begin
        finish_d = 1'b1;
        state_d  = IDLE;
        if (timeout_q) begin
          freq_d = '0;
          duty_d = '0;
          high_d = '0;
          low_d  = '0;
        end else begin
          freq_d = (fdvd_q > 32'(CNT_MAX)) ? CNT_MAX : fdvd_q[19:0];
          duty_d = ddvd_q[7:0];
          high_d = hcnt_q;
          low_d  = lcnt_q;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      period_q  <= '0;
      fdvd_q    <= '0;
      ddvd_q    <= '0;
      frem_q    <= '0;
      drem_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      freq_q    <= '0;
      duty_q    <= '0;
      high_q    <= '0;
      low_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      period_q  <= period_d;
      fdvd_q    <= fdvd_d;
      ddvd_q    <= ddvd_d;
      frem_q    <= frem_d;
      drem_q    <= drem_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
      freq_q    <= freq_d;
      duty_q    <= duty_d;
      high_q    <= high_d;
      low_q     <= low_d;
    end
  end

  assign busy      = busy_q;
  assign finish    = finish_q;
  assign freq      = freq_q;
  assign duty      = duty_q;
  assign high_time = high_q;
  assign low_time  = low_q;

endmodule

// File: tb/tb_signal_measure_core.sv
// Scoreboard bench for signal_measure_core: a waveform generator drives sig_in,
// expected results come from the period/duty arithmetic and a monitor compares on finish.
`timescale 1ns/1ps
module tb_signal_measure_core;

  localparam int CLK_FREQ       = 50_000_000;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int FREQ_SAT       = 1048575;

  typedef struct packed {
    logic [31:0] freq;
    logic [31:0] duty;
    logic [31:0] high;
    logic [31:0] low;
    logic [31:0] start;
    logic [31:0] min_lat;
    logic [31:0] max_lat;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        enable = 1'b0;
  logic        sig_in;
  logic        busy;
  logic        finish;
  logic [19:0] freq;
  logic [7:0]  duty;
  logic [19:0] high_time;
  logic [19:0] low_time;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   held_freq = 0, held_duty = 0, held_high = 0, held_low = 0;
  int   gen_h = 0, gen_l = 0;
  logic gen_dc = 1'b0;
  int   cur_h, cur_l;
  int   last_period = 1;

  always #10 clk = ~clk;

  signal_measure_core #(
    .CLK_FREQ(CLK_FREQ),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .sig_in(sig_in),
    .busy(busy),
    .finish(finish),
    .freq(freq),
    .duty(duty),
    .high_time(high_time),
    .low_time(low_time)
  );

  // Waveform generator: gen_h high cycles then gen_l low cycles, or a DC level when gen_h is 0.
  initial begin
    sig_in = 1'b0;
    forever begin
      if (gen_h == 0) begin
        sig_in = gen_dc;
        @(negedge clk);
      end else begin
        cur_h  = gen_h;
        cur_l  = gen_l;
        sig_in = 1'b1;
        repeat (cur_h) @(negedge clk);
        sig_in = 1'b0;
        repeat (cur_l) @(negedge clk);
      end
    end
  end

  function automatic exp_t model(input int h, input int l, input int start);
    exp_t e;
    int   p, f;
    p = h + l;
    f = (CLK_FREQ + p / 2) / p;
    if (f > FREQ_SAT) f = FREQ_SAT;
    e.freq    = f;
    e.duty    = (h * 100 + p / 2) / p;
    e.high    = h;
    e.low     = l;
    e.start   = start;
    e.min_lat = p + 30;
    e.max_lat = 2 * p + 45;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic monitorLoop();
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        held_freq = 0;
        held_duty = 0;
        held_high = 0;
        held_low  = 0;
      end else if (finish) begin
        checkOutput("busy_low_at_finish", 32'(busy), 0);
        checkOutput("pending_on_finish", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("freq", 32'(freq), e.freq);
          checkOutput("duty", 32'(duty), e.duty);
          checkOutput("high_time", 32'(high_time), e.high);
          checkOutput("low_time", 32'(low_time), e.low);
          lat = cyc - int'(e.start);
          checkRange("finish_latency", lat, e.min_lat, e.max_lat);
          held_freq = e.freq;
          held_duty = e.duty;
          held_high = e.high;
          held_low  = e.low;
        end
      end else begin
        checkOutput("held_freq", 32'(freq), held_freq);
        checkOutput("held_duty", 32'(duty), held_duty);
        checkOutput("held_high", 32'(high_time), held_high);
        checkOutput("held_low", 32'(low_time), held_low);
      end
    end
  endtask

  task automatic waitSigLevel(input logic level);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (sig_in == level) seen = 1'b1;
    end
    checkOutput("sig_level_seen", 32'(seen), 1);
  endtask

  task automatic setWave(input int h, input int l, input logic dc);
    int new_p;
    gen_h  = h;
    gen_l  = l;
    gen_dc = dc;
    new_p  = (h == 0) ? 1 : h + l;
    repeat (last_period + new_p + 10) @(negedge clk);
    last_period = new_p;
  endtask

  task automatic pulseIfBusy();
    if (busy) begin
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int h, input int l, input logic dc,
                               input int extra, input bit mid_high);
    exp_t e;
    bit   timed_out;
    setWave(h, l, dc);
    timed_out = (h == 0) || (h >= TIMEOUT_CYCLES) || (l >= TIMEOUT_CYCLES);
    if (mid_high) waitSigLevel(1'b0);
    checkOutput("busy_idle", 32'(busy), 0);
    if (timed_out) begin
      e         = '0;
      e.start   = cyc;
      e.min_lat = (h == 0) ? 995 : 0;
      e.max_lat = (h == 0) ? 1010 : 5000;
    end else begin
      e = model(h, l, cyc);
    end
    exp_q.push_back(e);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    checkOutput("busy_after_enable", 32'(busy), 1);
    if (mid_high) begin
      waitSigLevel(1'b1);
      repeat (10) @(negedge clk);
      pulseIfBusy();
      repeat (5) @(negedge clk);
      pulseIfBusy();
    end
    for (int k = 0; k < extra; k++) begin
      repeat ($urandom_range(3, 30)) @(negedge clk);
      pulseIfBusy();
    end
    for (int i = 0; i < 8000 && exp_q.size() > 0; i++) @(negedge clk);
    checkOutput("finish_seen", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    checkOutput("busy_after_finish", 32'(busy), 0);
  endtask

  task automatic resetMidMeasure();
    setWave(10, 200, 1'b0);
    waitSigLevel(1'b0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    waitSigLevel(1'b1);
    waitSigLevel(1'b0);
    repeat (20) @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_finish", 32'(finish), 0);
    checkOutput("rst_freq", 32'(freq), 0);
    checkOutput("rst_duty", 32'(duty), 0);
    checkOutput("rst_high", 32'(high_time), 0);
    checkOutput("rst_low", 32'(low_time), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("busy_after_reset", 32'(busy), 0);
  endtask

  initial begin
    fork
      monitorLoop();
    join_none

    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_finish", 32'(finish), 0);
    checkOutput("reset_freq", 32'(freq), 0);
    checkOutput("reset_duty", 32'(duty), 0);
    checkOutput("reset_high", 32'(high_time), 0);
    checkOutput("reset_low", 32'(low_time), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    applyStimulus(40, 60, 1'b0, 0, 1'b0);
    applyStimulus(25, 25, 1'b0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0, 0, 1'b0);
    applyStimulus(1, 1, 1'b0, 0, 1'b0);
    applyStimulus(40, 60, 1'b0, 0, 1'b1);
    resetMidMeasure();
    applyStimulus(40, 60, 1'b0, 0, 1'b0);
    applyStimulus(0, 0, 1'b1, 0, 1'b0);
    applyStimulus(1500, 20, 1'b0, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      applyStimulus(int'($urandom_range(1, 60)), int'($urandom_range(1, 60)), 1'b0,
                    int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signal_measure_core.md
# signal_measure_core

Single-shot frequency and duty-cycle meter for a digital input. A one-cycle `enable` pulse starts a measurement: the block times one full period of `sig_in` in system-clock cycles, then derives frequency in Hz and duty in percent with sequential dividers. It sits behind the register/bus layer of the debugger's measurement subsystem. Results are held until the next measurement completes.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz; this is the dividend for the frequency calculation.
- `TIMEOUT_CYCLES`, default `CLK_FREQ`: maximum cycles spent in any waiting or counting state before the measurement is aborted.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: the port keeps the codebase name, but reset is asynchronous and active-high. `rst_n`=1 resets the block.
- `enable` in 1: start pulse. Sampled only in IDLE.
- `sig_in` in 1: signal under test, asynchronous to `clk`.
- `busy` out 1: high while a measurement is in progress.
- `finish` out 1: one-cycle pulse when the results are valid.
- `freq` out 20: measured frequency in Hz. Saturates at 1,048,575.
- `duty` out 8: high-time percentage, 0–100, rounded to nearest.
- `high_time` out 20: high-phase length in clk cycles.
- `low_time` out 20: low-phase length in clk cycles.

## Operation
- **Input conditioning:** `sig_in` passes through a 2-FF synchronizer, then a registered copy provides edge detection.
  - Rise = synced level 1 and previous level 0.
  - Fall = synced level 0 and previous level 1.
- **IDLE:** `busy`=0. When `enable`=1, go to WAIT_RISE and clear the cycle counters.
- **WAIT_RISE:** wait for a rise.
  - On the rise cycle: `hcnt`=1, go to MEAS_HIGH.
- **MEAS_HIGH:** increment `hcnt` each cycle the synced level is 1.
  - On a fall: `lcnt`=1, go to MEAS_LOW.
- **MEAS_LOW:** increment `lcnt` each cycle the synced level is 0.
  - On the next rise: latch `period = hcnt + lcnt` (21 bits), go to CALC.
- **CALC:** two 32-bit restoring dividers run in parallel, one quotient bit per cycle, 32 cycles.
  - `q_f = (CLK_FREQ + period/2) / period`
  - `q_d = (hcnt*100 + period/2) / period`
  - Then go to DONE.
- **DONE (one cycle):** register the outputs and pulse `finish`.
  - `freq` = min(`q_f`, 2^20−1).
  - `duty` = `q_d`.
  - `high_time` = `hcnt`.
  - `low_time` = `lcnt`.
  - Return to IDLE.
- **Timeout:** a watchdog counter runs in WAIT_RISE, MEAS_HIGH and MEAS_LOW. If it reaches `TIMEOUT_CYCLES` (DC input or period too long), go directly to DONE with all four outputs = 0.
- **Counter saturation:** `hcnt`/`lcnt` saturate at 2^20−1; they never wrap.
- **`enable` while busy:** ignored; it does not restart the measurement.
- **Simultaneous `enable` and a `sig_in` edge in IDLE:** the edge is not counted. Measurement begins at the next rise seen in WAIT_RISE.
- **Reset mid-measurement:** the state returns to IDLE immediately and all outputs are cleared.

## Timing
- **Reset values:** `busy`=0, `finish`=0, `freq`=0, `duty`=0, `high_time`=0, `low_time`=0, state IDLE, synchronizer flops 0.
- **`busy`:**
  - Rises in the cycle after `enable` is sampled.
  - Falls in the same cycle `finish` is asserted; `busy` and `finish` are never both 1.
- **`finish`:**
  - Exactly one cycle wide.
  - Outputs change only in the `finish` cycle and are stable from then on.
- **Latency:**
  - Input edge to edge detection: 2–3 clk cycles.
  - Terminating rise to `finish`: 34 cycles (1 latch, 32 divide, 1 DONE).
- **Minimum measurable phase:** 1 cycle (period 2, which gives `freq` saturated at 1,048,575).

## Test plan
- Period 2000 ns, 40 % duty, 50 MHz clk, `enable` pulse → `finish` pulse; `freq`=500000, `duty`=40, `high_time`=40, `low_time`=60.
- Change to period 1000 ns, 50 % duty, then re-trigger → `freq`=1000000, `duty`=50, `high_time`=25, `low_time`=25; previous results held until this `finish`.
- `sig_in` held 0, `TIMEOUT_CYCLES`=1000 → `finish` within ~1003 cycles; all outputs 0; `busy` then 0.
- Period 40 ns (2 cycles, 50 %) → `freq`=1048575 (saturated), `duty`=50, `high_time`=1, `low_time`=1.
- Extra `enable` pulses during MEAS_HIGH → ignored; single `finish`; results as in the first scenario.
- Assert `rst_n`=1 during MEAS_LOW → asynchronously `busy`=0 and all outputs 0; no `finish`; a new `enable` after release measures correctly.
